div_clz_skip: RTL and testbench

- Multicycle radix-2 restoring divider for DIV/DIVU; sits directly downstream of the CPU's count-leading-zeros unit.
- Outputs |dividend| combinationally. The parent routes it through the clz unit and returns the count on dividend_clz in the same cycle.
- The leading-zero count pre-normalises the dividend, so only 32-clz iterations run.
- Quotient and remainder are presented to the HI/LO write path with a one-cycle done pulse.

---
 rtl/div_clz_skip.sv | 75 +++++++
 tb/tb_div_clz_skip.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/div_clz_skip.sv
// div_clz_skip: multicycle restoring DIV/DIVU that runs only 32-clz iterations using an external clz count
module div_clz_skip #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] abs_dividend,
  input  logic [5:0]       dividend_clz,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q;
  logic [WIDTH-1:0] dvs_q, dvd_q, work_q, rem_q, q_q, diff;
  logic [5:0] count_q;
  logic qneg_q, rneg_q, dz_q, ge;
  logic [WIDTH:0] t;
  assign abs_dividend = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign t = {rem_q, work_q[WIDTH-1]};
  assign ge = t >= {1'b0, dvs_q};
  assign diff = t[WIDTH-1:0] - dvs_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          dvs_q <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
          dvd_q <= dividend;
          qneg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_q <= is_signed & dividend[WIDTH-1];
          work_q <= abs_dividend << dividend_clz;
          count_q <= 6'd32 - dividend_clz;
          rem_q <= '0;
          q_q <= '0;
          dz_q <= divisor == '0;
          busy <= 1'b1;
          state_q <= (divisor == '0 || dividend_clz == 6'd32) ? FIX : CALC;
        end
        CALC: begin
          rem_q <= ge ? diff : t[WIDTH-1:0];
          q_q <= {q_q[WIDTH-2:0], ge};
          work_q <= work_q << 1;
          count_q <= count_q - 6'd1;
          state_q <= count_q == 6'd1 ? FIX : CALC;
        end
        FIX: begin
          quotient <= dz_q ? '1 : qneg_q ? -q_q : q_q;
          remainder <= dz_q ? dvd_q : rneg_q ? -rem_q : rem_q;
          div_by_zero <= dz_q;
          busy <= 1'b0;
          done <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_clz_skip.sv
// tb_div_clz_skip: directed table, random model comparison and abort/ignore sequences for div_clz_skip
module tb_div_clz_skip;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, is_signed = 1'b0;
  logic [31:0] dividend = '0, divisor = '0, abs_dividend, quotient, remainder;
  logic [5:0] dividend_clz;
  logic busy, done, div_by_zero;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  function automatic logic [5:0] clz32(input logic [31:0] x);
    for (int i = 31; i >= 0; i--) if (x[i]) return 6'(31 - i);
    return 6'd32;
  endfunction
  assign dividend_clz = clz32(abs_dividend);
  div_clz_skip dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .abs_dividend(abs_dividend),
    .dividend_clz(dividend_clz), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  typedef struct {
    logic s;
    logic [31:0] a, b, q, r;
    logic dz;
    int lat;
  } vec_t;
  localparam int NV = 9;
  vec_t vt[NV];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output int lat);
    logic [31:0] mag;
    dz = b == 0;
    if (dz) begin
      q = '1;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    mag = (s && a[31]) ? -a : a;
    lat = (dz || a == 0) ? 2 : 34 - int'(clz32(mag));
  endfunction
  task automatic run_check(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz,
                           input int elat, input bit poke_done);
    int lat, bn;
    lat = 0;
    bn = 0;
    @(negedge clk);
    is_signed = s;
    dividend = a;
    divisor = b;
    start = 1'b1;
    #1 chk({nm, " abs"}, abs_dividend, (s && a[31]) ? -a : a);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (busy) bn++;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk({nm, " latency"}, 32'(lat), 32'(elat));
    chk({nm, " busy cycles"}, 32'(bn), 32'(elat - 1));
    chk({nm, " quotient"}, quotient, eq);
    chk({nm, " remainder"}, remainder, er);
    chk({nm, " dz"}, 32'(div_by_zero), 32'(edz));
    if (poke_done) begin
      start = 1'b1;
      dividend = 32'd55;
      divisor = 32'd4;
    end
    @(negedge clk);
    start = 1'b0;
    chk({nm, " done pulse"}, 32'(done), 32'd0);
    if (poke_done) begin
      chk({nm, " start in DONE ignored"}, 32'(busy), 32'd0);
      chk({nm, " held quotient"}, quotient, eq);
    end
  endtask
  initial begin
    logic [31:0] a, b, q, r;
    logic s, dz;
    int lat, seen;
    vt[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 9};
    vt[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 5};
    vt[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34};
    vt[3] = '{1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2};
    vt[4] = '{1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 2};
    vt[5] = '{1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 5};
    vt[6] = '{1'b0, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0, 34};
    vt[7] = '{1'b1, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 2};
    vt[8] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 9};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset dz", 32'(div_by_zero), 32'd0);
    for (int i = 0; i < NV; i++)
      run_check($sformatf("vec%0d", i), vt[i].s, vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, vt[i].lat, i == 0);
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      ref_div(s, a, b, q, r, dz, lat);
      run_check($sformatf("rnd%0d", i), s, a, b, q, r, dz, lat, 1'b0);
    end
    @(negedge clk);
    is_signed = 1'b0;
    dividend = 32'hFFFF_FFFF;
    divisor = 32'd1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 10; k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("abort no done", 32'(seen), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort quotient", quotient, 32'd0);
    chk("abort remainder", remainder, 32'd0);
    is_signed = 1'b0;
    dividend = 32'hFFFF_FFFF;
    divisor = 32'd1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (k == 5) begin
        start = 1'b1;
        dividend = 32'd10;
        divisor = 32'd3;
      end
      if (k == 6) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("restart latency", 32'(lat), 32'd34);
    chk("restart quotient", quotient, 32'hFFFF_FFFF);
    chk("restart remainder", remainder, 32'd0);
    chk("restart dz", 32'(div_by_zero), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
